mux_arbiter_4: RTL and testbench



---
 rtl/arb_pkg.sv | 35 +++
 rtl/mux_4to1.sv | 13 +
 rtl/mux_arbiter_4.sv | 125 ++++++++++++
 tb/tb_mux_arbiter_4.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Result of a round-robin search: a winner index plus whether any request was found.
    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Search last+1, last+2, last+3, last (mod 4); the first asserted request wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   last);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + SEL_W'(k);
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Plain combinational 4:1 single-bit multiplexer.
module mux_4to1
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] data_in,
    input  logic [SEL_W-1:0]   select,
    output logic               data_out
);

    // Route the selected requester's data bit to the output.
    assign data_out = data_in[select];

endmodule

// File: rtl/mux_arbiter_4.sv
// Round-robin arbiter sharing one mux_4to1 among four requesters, with a
// bounded-hold counter that forces rotation under contention.
//
// Handshake: a requester holds req[i] high for as long as it wants the mux.
// gnt[i] rises one edge after req[i] is seen and the owner keeps it while
// req[i] stays high, unless the hold limit is reached with another request
// pending. Dropping req[i] releases the grant at the next edge.
module mux_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   select,
    output logic               busy,
    output logic               data_out,
    output logic               data_valid,
    output arb_state_t         state_dbg
);

    // Counter value at which the current owner has used up its hold window.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t          state, state_n;
    logic [SEL_W-1:0]    last, last_n;
    logic [7:0]          cnt, cnt_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic [SEL_W-1:0]    select_n;
    logic                busy_n;
    logic [NUM_REQ-1:0]  others;
    logic                own_req;
    pick_t               pick_any;
    pick_t               pick_oth;
    logic                mux_out;

    assign state_dbg = state;

    mux_4to1 u_mux (
        .data_in  (data_in),
        .select   (select),
        .data_out (mux_out)
    );

    // State, pointer, counter and all output flops; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 2'd3;
            cnt        <= '0;
            gnt        <= '0;
            select     <= '0;
            busy       <= 1'b0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_n;
            last       <= last_n;
            cnt        <= cnt_n;
            gnt        <= gnt_n;
            select     <= select_n;
            busy       <= busy_n;
            data_valid <= (gnt != '0);
            if (gnt != '0) begin
                data_out <= mux_out;
            end
        end
    end

    // Next-state, pointer and hold counter. While granted, last is the owner,
    // so searching the other requests from last naturally skips the owner and
    // sends a preempted requester to the back of the queue.
    always_comb begin
        state_n  = state;
        last_n   = last;
        cnt_n    = cnt;
        own_req  = req[last];
        others   = req & ~(NUM_REQ'(1) << last);
        pick_any = rr_pick(req, last);
        pick_oth = rr_pick(others, last);
        case (state)
            IDLE: begin
                if (pick_any.found) begin
                    state_n = GRANT;
                    last_n  = pick_any.idx;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (own_req) begin
                    if (cnt < HOLD_LAST) begin
                        cnt_n = cnt + 8'd1;
                    end else if (pick_oth.found) begin
                        last_n = pick_oth.idx;
                        cnt_n  = '0;
                    end
                end else if (pick_oth.found) begin
                    last_n = pick_oth.idx;
                    cnt_n  = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs derived from the next state; select holds while idle.
    always_comb begin
        gnt_n    = '0;
        select_n = select;
        busy_n   = 1'b0;
        if (state_n == GRANT) begin
            gnt_n    = NUM_REQ'(1) << last_n;
            select_n = last_n;
            busy_n   = 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Self-checking bench for mux_arbiter_4 with MAX_HOLD = 8.
module tb_mux_arbiter_4;
    import arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] gnt;
    logic [1:0] select;
    logic       busy;
    logic       data_out;
    logic       data_valid;
    arb_state_t state_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_q[$];
    logic [0:0] exp_d_q[$];

    mux_arbiter_4 #(.MAX_HOLD(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_in    (data_in),
        .gnt        (gnt),
        .select     (select),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        data_in = 4'b0000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        rst_n   = 1'b0;
        req     = 4'b0000;
        data_in = 4'b0000;
        #3;
        n_chk++;
        if ({gnt, select, busy, data_out, data_valid} !== 9'd0)
            $display("FAIL reset_outputs: got gnt=%b sel=%0d busy=%b dout=%b dv=%b, want all 0",
                     gnt, select, busy, data_out, data_valid);
        else n_pass++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(4'b0000);
            step();
            e = exp_q.pop_front();
            n_chk++;
            if (gnt !== e || select !== 2'd0 || busy !== 1'b0 || data_valid !== 1'b0)
                $display("FAIL idle_cycle%0d: got gnt=%b sel=%0d busy=%b dv=%b, want gnt=%b sel=0 busy=0 dv=0",
                         i, gnt, select, busy, data_valid, e);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [3:0] e;
        do_reset();
        req     = 4'b0100;
        data_in = 4'b0100;
        exp_q.push_back(4'b0100);
        step();
        e = exp_q.pop_front();
        n_chk++;
        if (gnt !== e || select !== 2'd2 || busy !== 1'b1)
            $display("FAIL single_grant: got gnt=%b sel=%0d busy=%b, want gnt=%b sel=2 busy=1",
                     gnt, select, busy, e);
        else n_pass++;
        exp_d_q.push_back(1'b1);
        step();
        n_chk++;
        if (data_out !== exp_d_q.pop_front() || data_valid !== 1'b1)
            $display("FAIL single_data: got dout=%b dv=%b, want dout=1 dv=1", data_out, data_valid);
        else n_pass++;
        req = 4'b0000;
        exp_q.push_back(4'b0000);
        step();
        e = exp_q.pop_front();
        n_chk++;
        if (gnt !== e || busy !== 1'b0 || select !== 2'd2)
            $display("FAIL single_release: got gnt=%b busy=%b sel=%0d, want gnt=%b busy=0 sel=2",
                     gnt, busy, select, e);
        else n_pass++;
        step();
        n_chk++;
        if (data_valid !== 1'b0 || data_out !== 1'b1)
            $display("FAIL single_idle_data: got dv=%b dout=%b, want dv=0 dout=1 (held)",
                     data_valid, data_out);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        int prev;
        do_reset();
        req  = 4'b1111;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            int o;
            o = i % 4;
            exp_q.push_back(4'(1) << o);
            exp_q.push_back(4'(1) << o);
            step();
            e = exp_q.pop_front();
            n_chk++;
            if (gnt !== e || busy !== 1'b1)
                $display("FAIL rr_turn%0d_first: got gnt=%b busy=%b, want gnt=%b busy=1", i, gnt, busy, e);
            else n_pass++;
            if (prev >= 0) req[prev] = 1'b1;
            step();
            e = exp_q.pop_front();
            n_chk++;
            if (gnt !== e)
                $display("FAIL rr_turn%0d_second: got gnt=%b, want gnt=%b", i, gnt, e);
            else n_pass++;
            req[o] = 1'b0;
            prev   = o;
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_preempt();
        logic [3:0] e;
        logic [3:0] g_prev;
        do_reset();
        req    = 4'b0011;
        g_prev = 4'b0000;
        for (int ed = 1; ed <= 24; ed++) begin
            logic [3:0] g;
            g = ((((ed - 1) / 8) % 2) == 0) ? 4'b0001 : 4'b0010;
            data_in = 4'($urandom_range(0, 15));
            if (ed >= 2) exp_d_q.push_back(data_in[(g_prev == 4'b0001) ? 0 : 1]);
            exp_q.push_back(g);
            step();
            e = exp_q.pop_front();
            n_chk++;
            if (gnt !== e || busy !== 1'b1)
                $display("FAIL preempt_edge%0d: got gnt=%b busy=%b, want gnt=%b busy=1", ed, gnt, busy, e);
            else n_pass++;
            if (ed >= 2) begin
                logic [0:0] d;
                d = exp_d_q.pop_front();
                n_chk++;
                if (data_out !== d || data_valid !== 1'b1)
                    $display("FAIL preempt_data%0d: got dout=%b dv=%b, want dout=%b dv=1",
                             ed, data_out, data_valid, d);
                else n_pass++;
            end
            g_prev = g;
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_handover();
        logic [3:0] e;
        do_reset();
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        step();
        req = 4'b1010;
        exp_q.push_back(4'b0010);
        step();
        e = exp_q.pop_front();
        n_chk++;
        if (e !== 4'b0010 || gnt !== exp_q.pop_front())
            $display("FAIL handover_hold: got gnt=%b, want gnt=0010", gnt);
        else n_pass++;
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        step();
        e = exp_q.pop_front();
        n_chk++;
        if (gnt !== e || select !== 2'd3 || busy !== 1'b1)
            $display("FAIL handover_move: got gnt=%b sel=%0d busy=%b, want gnt=%b sel=3 busy=1",
                     gnt, select, busy, e);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        // Leaves gnt = 1000 from test_handover; one more edge fills data_valid.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({gnt, select, busy, data_out, data_valid} !== 9'd0)
            $display("FAIL async_reset: got gnt=%b sel=%0d busy=%b dout=%b dv=%b, want all 0",
                     gnt, select, busy, data_out, data_valid);
        else n_pass++;
        req = 4'b1001;
        #1;
        rst_n = 1'b1;
        exp_q.push_back(4'b0001);
        step();
        e = exp_q.pop_front();
        n_chk++;
        if (gnt !== e || select !== 2'd0)
            $display("FAIL restart_grant: got gnt=%b sel=%0d, want gnt=%b sel=0", gnt, select, e);
        else n_pass++;
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 4'b0000;
        data_in = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_handover();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
